// File: rtl/note_metadata_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : note_metadata_reader_if
// Description : Bundle between the note metadata reader, the note BRAM read
//               port and the note consumer.
//               master : the reader. Drives mem_addr and the note fields,
//                        and receives mem_dout and note_ready.
//               slave  : the memory and consumer side.
//               mem_addr   - BRAM read address
//               mem_dout   - BRAM read data (32-bit note word)
//               note_valid - the note fields hold a note
//               note_ready - the consumer takes the note when valid & ready
//               note_pitch / note_string / note_fret / note_time - decoded
//                            fields of the note word
// Revision    : 1.0 - initial release
// ============================================================================
interface note_metadata_reader_if #(
    parameter int LOGSIZE = 12
) ();
    logic [LOGSIZE-1:0] mem_addr;
    logic [31:0]        mem_dout;
    logic               note_valid;
    logic               note_ready;
    logic [5:0]         note_pitch;
    logic [2:0]         note_string;
    logic [3:0]         note_fret;
    logic [15:0]        note_time;

    modport master (
        output mem_addr,
        input  mem_dout,
        output note_valid,
        input  note_ready,
        output note_pitch,
        output note_string,
        output note_fret,
        output note_time
    );

    modport slave (
        input  mem_addr,
        output mem_dout,
        input  note_valid,
        output note_ready,
        input  note_pitch,
        input  note_string,
        input  note_fret,
        input  note_time
    );
endinterface
`default_nettype wire

// File: rtl/note_metadata_reader.sv
`default_nettype none
// ============================================================================
// Module      : note_metadata_reader
// Description : Playback-side reader for the note metadata BRAM. Walks the
//               32-bit note words in address order. It presents each note
//               once song_time + LEAD reaches the note time. It also owns
//               the song-time counter.
//               Note word: [31:29] code (000 note, 111 end, others skipped),
//                          [28:23] pitch, [22:20] string, [19:16] fret,
//                          [15:0] time.
// Ports       : clk, reset  - clock, asynchronous active-high reset
//               start       - one-cycle pulse; starts playback from address 0
//                             when the reader is idle or done
//               tick        - 1 ms time-base strobe that advances song_time
//               pause       - (NOTE_READER_PAUSE_EN only) freezes song_time
//                             and holds back the release of new notes
//               bus         - master side of note_metadata_reader_if
//                             (BRAM read port and note handshake)
//               song_time   - ticks since start. Saturates at 16'hFFFF.
//               playing     - high from start until the end of data
//               done        - high once the end of data is reached
// Config      : `define NOTE_READER_PAUSE_EN to add the pause input.
// Revision    : 1.0 - initial release
// ============================================================================
module note_metadata_reader #(
    parameter int          LOGSIZE = 12,
    parameter logic [15:0] LEAD    = 16'd2000
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               start,
    input  wire logic               tick,
`ifdef NOTE_READER_PAUSE_EN
    input  wire logic               pause,
`endif
    note_metadata_reader_if.master  bus,
    output logic [15:0]             song_time,
    output logic                    playing,
    output logic                    done
);

    localparam logic [LOGSIZE-1:0] c_addr_one  = {{(LOGSIZE-1){1'b0}}, 1'b1};
    localparam logic [LOGSIZE-1:0] c_addr_last = {LOGSIZE{1'b1}};
    localparam logic [15:0]        c_time_max  = 16'hFFFF;
    localparam logic [2:0]         c_code_note = 3'b000;
    localparam logic [2:0]         c_code_end  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_DECODE = 3'd3,
        S_HOLD   = 3'd4,
        S_EMIT   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t             r_state;
    logic [LOGSIZE-1:0] r_mem_addr;
    logic               r_note_valid;
    logic [5:0]         r_note_pitch;
    logic [2:0]         r_note_string;
    logic [3:0]         r_note_fret;
    logic [15:0]        r_note_time;
    logic [15:0]        r_song_time;
    logic               r_playing;
    logic               r_done;

    logic               w_pause;
    logic [2:0]         w_code;
    logic               w_release;
    logic               w_last_addr;
    logic               w_accept;
    logic               w_tick_en;

`ifdef NOTE_READER_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_code      = bus.mem_dout[31:29];
    assign w_last_addr = (r_mem_addr == c_addr_last);
    assign w_accept    = r_note_valid & bus.note_ready;

    // Extend to 17 bits so that a large LEAD near the end of the 16-bit time
    // range cannot wrap around and hold back a note indefinitely.
    assign w_release = (({1'b0, r_song_time} + {1'b0, LEAD}) >= {1'b0, r_note_time});

    // song_time runs from start onward. It keeps counting after the end of
    // data so that the game can time out its tail. It stops only at reset
    // (or in IDLE, before the first start).
    assign w_tick_en = tick & ~w_pause & (r_state != S_IDLE) &
                       (r_song_time != c_time_max);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_mem_addr    <= '0;
            r_note_valid  <= 1'b0;
            r_note_pitch  <= '0;
            r_note_string <= '0;
            r_note_fret   <= '0;
            r_note_time   <= '0;
            r_song_time   <= '0;
            r_playing     <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            if (w_tick_en) begin
                r_song_time <= r_song_time + 16'd1;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    // A start overrides a tick in the same cycle, so every
                    // playback begins at exactly song_time == 0.
                    if (start) begin
                        r_song_time <= '0;
                        r_mem_addr  <= '0;
                        r_playing   <= 1'b1;
                        r_done      <= 1'b0;
                        r_state     <= S_FETCH;
                    end
                end

                // The BRAM registers its read address at the end of FETCH.
                // Its data is stable by DECODE.
                S_FETCH: r_state <= S_WAIT;
                S_WAIT:  r_state <= S_DECODE;

                S_DECODE: begin
                    if (w_code == c_code_end) begin
                        r_playing <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (w_code == c_code_note) begin
                        r_note_pitch  <= bus.mem_dout[28:23];
                        r_note_string <= bus.mem_dout[22:20];
                        r_note_fret   <= bus.mem_dout[19:16];
                        r_note_time   <= bus.mem_dout[15:0];
                        r_state       <= S_HOLD;
                    end else if (w_last_addr) begin
                        // Reserved code in the last word: nothing more to
                        // read.
                        r_playing <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_mem_addr <= r_mem_addr + c_addr_one;
                        r_state    <= S_FETCH;
                    end
                end

                S_HOLD: begin
                    if (w_release && !w_pause) begin
                        r_note_valid <= 1'b1;
                        r_state      <= S_EMIT;
                    end
                end

                S_EMIT: begin
                    if (w_accept) begin
                        r_note_valid <= 1'b0;
                        if (w_last_addr) begin
                            r_playing <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_mem_addr <= r_mem_addr + c_addr_one;
                            r_state    <= S_FETCH;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_addr    = r_mem_addr;
    assign bus.note_valid  = r_note_valid;
    assign bus.note_pitch  = r_note_pitch;
    assign bus.note_string = r_note_string;
    assign bus.note_fret   = r_note_fret;
    assign bus.note_time   = r_note_time;
    assign song_time       = r_song_time;
    assign playing         = r_playing;
    assign done            = r_done;

endmodule
`default_nettype wire

// File: tb/tb_note_metadata_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_note_metadata_reader
// Description : Self-checking bench for note_metadata_reader. There are two
//               instances: dut0 (LOGSIZE=2, LEAD=0) and dut1 (LOGSIZE=2,
//               LEAD=2000). Each one has a small registered-read BRAM model.
//               The stimulus pushes the expected notes into per-instance
//               queues. Monitors pop and compare them on every accepted note.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_metadata_reader;

    typedef struct packed {
        logic [5:0]  p;
        logic [2:0]  s;
        logic [3:0]  f;
        logic [15:0] t;
    } note_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start0 = 1'b0, tick0 = 1'b0;
    logic start1 = 1'b0, tick1 = 1'b0;
    logic [15:0] song_time0, song_time1;
    logic playing0, playing1, done0, done1;

    int checks = 0;
    int fails  = 0;

    note_t q0[$];
    note_t q1[$];

    logic [31:0] mem0 [0:3];
    logic [31:0] mem1 [0:3];

    always #5 clk = ~clk;

    note_metadata_reader_if #(.LOGSIZE(2)) if0 ();
    note_metadata_reader_if #(.LOGSIZE(2)) if1 ();

    note_metadata_reader #(.LOGSIZE(2), .LEAD(16'd0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .tick(tick0),
`ifdef NOTE_READER_PAUSE_EN
        .pause(1'b0),
`endif
        .bus(if0.master), .song_time(song_time0), .playing(playing0), .done(done0)
    );

    note_metadata_reader #(.LOGSIZE(2), .LEAD(16'd2000)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .tick(tick1),
`ifdef NOTE_READER_PAUSE_EN
        .pause(1'b0),
`endif
        .bus(if1.master), .song_time(song_time1), .playing(playing1), .done(done1)
    );

    // Registered-read block RAM models
    always @(posedge clk) if0.mem_dout <= mem0[if0.mem_addr];
    always @(posedge clk) if1.mem_dout <= mem1[if1.mem_addr];

    note_t cur0, cur1;
    assign cur0 = {if0.note_pitch, if0.note_string, if0.note_fret, if0.note_time};
    assign cur1 = {if1.note_pitch, if1.note_string, if1.note_fret, if1.note_time};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic note_t mk(input int p, input int s, input int f, input int t);
        mk.p = 6'(p); mk.s = 3'(s); mk.f = 4'(f); mk.t = 16'(t);
    endfunction

    function automatic logic [31:0] word(input note_t n);
        word = {3'b000, n};
    endfunction

    // Monitors: stability while stalled, and scoreboard compare on accept
    note_t hold0, hold1;
    bit stall0 = 0, stall1 = 0;

    always @(negedge clk) begin
        if (reset) begin
            stall0 = 0;
        end else begin
            if (stall0) begin
                chk("stall_valid0", 32'(if0.note_valid), 32'd1);
                chk("stall_fields0", 32'(cur0), 32'(hold0));
            end
            if (if0.note_valid && if0.note_ready) begin
                if (q0.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_note0: got 0x%0h, expected no note", cur0);
                end else begin
                    chk("note0", 32'(cur0), 32'(q0.pop_front()));
                end
            end
            stall0 = if0.note_valid && !if0.note_ready;
            hold0  = cur0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            stall1 = 0;
        end else begin
            if (stall1) begin
                chk("stall_valid1", 32'(if1.note_valid), 32'd1);
                chk("stall_fields1", 32'(cur1), 32'(hold1));
            end
            if (if1.note_valid && if1.note_ready) begin
                if (q1.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_note1: got 0x%0h, expected no note", cur1);
                end else begin
                    chk("note1", 32'(cur1), 32'(q1.pop_front()));
                end
            end
            stall1 = if1.note_valid && !if1.note_ready;
            hold1  = cur1;
        end
    end

    task automatic pulse_start0();
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
    endtask

    task automatic pulse_tick0();
        @(posedge clk); #1 tick0 = 1'b1;
        @(posedge clk); #1 tick0 = 1'b0;
    endtask

    task automatic wait_done0(input string name);
        for (int i = 0; i < 100 && !done0; i++) @(posedge clk);
        #1 chk(name, 32'(done0), 32'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        if0.note_ready = 1'b0;
        if1.note_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin mem0[i] = 32'hE0000000; mem1[i] = 32'hE0000000; end

        // ---------------- reset values ----------------
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_addr", 32'(if0.mem_addr), 32'd0);
        chk("rst_valid", 32'(if0.note_valid), 32'd0);
        chk("rst_fields", 32'(cur0), 32'd0);
        chk("rst_song_time", 32'(song_time0), 32'd0);
        chk("rst_playing", 32'(playing0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);

        // ---- T1: note at 100 (pitch1 str2 fret3), LEAD=0; stalled 20 cycles ----
        mem0[0] = 32'h00A30064;
        mem0[1] = 32'hE0000000;
        q0.push_back(mk(1, 2, 3, 100));
        pulse_start0();
        repeat (10) @(posedge clk);
        #1 chk("t1_playing", 32'(playing0), 32'd1);
        chk("t1_valid_t0", 32'(if0.note_valid), 32'd0);
        for (int i = 0; i < 99; i++) pulse_tick0();
        chk("t1_song_time99", 32'(song_time0), 32'd99);
        chk("t1_valid_t99", 32'(if0.note_valid), 32'd0);
        pulse_tick0();
        chk("t1_valid_same_cycle", 32'(if0.note_valid), 32'd0);
        chk("t1_song_time100", 32'(song_time0), 32'd100);
        @(posedge clk); #1;
        chk("t1_valid_next_cycle", 32'(if0.note_valid), 32'd1);
        repeat (20) @(posedge clk);
        #1 if0.note_ready = 1'b1;
        @(posedge clk); #1 if0.note_ready = 1'b0;
        chk("t1_valid_dropped", 32'(if0.note_valid), 32'd0);
        wait_done0("t1_done");
        chk("t1_playing_low", 32'(playing0), 32'd0);
        chk("t1_sb_empty", 32'(q0.size()), 32'd0);

        // ---- T2: note at 1500, LEAD=2000 -> released at song_time 0 ----
        mem1[0] = word(mk(5, 1, 7, 1500));
        mem1[1] = 32'hE0000000;
        q1.push_back(mk(5, 1, 7, 1500));
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (if1.note_valid) begin n = i; break; end
        end
        chk("t2_valid_within_5", 32'((n >= 1) && (n <= 5)), 32'd1);
        chk("t2_song_time", 32'(song_time1), 32'd0);
        for (int i = 0; i < 50 && !done1; i++) @(posedge clk);
        #1 chk("t2_done", 32'(done1), 32'd1);
        chk("t2_sb_empty", 32'(q1.size()), 32'd0);

        // ---- T4: reserved code word at address 1 is skipped ----
        mem0[0] = word(mk(2, 3, 4, 0));
        mem0[1] = 32'h40000000;
        mem0[2] = word(mk(6, 5, 9, 0));
        mem0[3] = 32'hE0000000;
        q0.push_back(mk(2, 3, 4, 0));
        q0.push_back(mk(6, 5, 9, 0));
        if0.note_ready = 1'b1;
        pulse_start0();
        chk("t4_done_cleared", 32'(done0), 32'd0);
        wait_done0("t4_done");
        chk("t4_sb_empty", 32'(q0.size()), 32'd0);

        // ---- T5: memory full of notes, no end marker ----
        for (int i = 0; i < 4; i++) begin
            mem0[i] = word(mk(10 + i, i, 12 - i, 0));
            q0.push_back(mk(10 + i, i, 12 - i, 0));
        end
        pulse_start0();
        wait_done0("t5_done");
        chk("t5_addr", 32'(if0.mem_addr), 32'd3);
        chk("t5_sb_empty", 32'(q0.size()), 32'd0);

        // ---- T6: asynchronous reset while note_valid=1, then replay ----
        mem0[0] = word(mk(7, 7, 15, 0));
        mem0[1] = 32'hE0000000;
        if0.note_ready = 1'b0;
        pulse_start0();
        for (int i = 0; i < 10 && !if0.note_valid; i++) begin @(posedge clk); #1; end
        chk("t6_valid_before_reset", 32'(if0.note_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(if0.note_valid), 32'd0);
        chk("t6_rst_fields", 32'(cur0), 32'd0);
        chk("t6_rst_addr", 32'(if0.mem_addr), 32'd0);
        chk("t6_rst_song_time", 32'(song_time0), 32'd0);
        chk("t6_rst_playing", 32'(playing0), 32'd0);
        chk("t6_rst_done", 32'(done0), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        q0.push_back(mk(7, 7, 15, 0));
        if0.note_ready = 1'b1;
        pulse_start0();
        wait_done0("t6_replay_done");
        chk("t6_sb_empty", 32'(q0.size()), 32'd0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/note_metadata_reader.md
# note_metadata_reader

Playback-side reader for the note metadata memory: walks the 32-bit note words that the metadata loader stored in block RAM, in address order, and presents each note to the game logic once the song clock reaches the note's time minus a configurable lead. It sits between the note BRAM read port and the note-spawn/scoring logic, and owns the song-time counter.

## Interface
- LOGSIZE, 12, memory address width (2^LOGSIZE words)
- LEAD, 16'd2000, lead in ticks; a note is released when song_time + LEAD >= note time
- clk  input  1  system clock (100 MHz)
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins playback from address 0 (ignored unless IDLE or DONE)
- tick  input  1  one-cycle time-base strobe (1 ms); advances song_time
- mem_addr  output  LOGSIZE  BRAM read address (registered)
- mem_dout  input  32  BRAM read data
- note_valid  output  1  note fields valid
- note_ready  input  1  consumer accepts note when note_valid & note_ready
- note_pitch  output  6  word[28:23]
- note_string  output  3  word[22:20]
- note_fret  output  4  word[19:16]
- note_time  output  16  word[15:0]
- song_time  output  16  ticks since start
- playing  output  1  high from start until DONE
- done  output  1  high in DONE, cleared by start or reset

## Operation
- Word format: [31:29] system code (000 note, 111 end of data, others reserved), [28:23] pitch, [22:20] string, [19:16] fret, [15:0] time.
- States: IDLE, FETCH, WAIT, DECODE, HOLD, EMIT, DONE.
- IDLE: on start -> song_time=0, mem_addr=0, playing=1, -> FETCH.
- FETCH: mem_addr stable; -> WAIT. WAIT: -> DECODE (mem_dout sampled in DECODE, i.e. 2 cycles after mem_addr update).
- DECODE: code 111 -> DONE; code 000 -> latch fields into holding register, -> HOLD; reserved code -> skip word (advance address, -> FETCH).
- HOLD: when {1'b0,song_time}+LEAD >= {1'b0,note_time} (17-bit compare, no wrap) -> EMIT, note_valid=1.
- EMIT: note fields and note_valid held stable until note_ready; on accept -> note_valid=0, advance address, -> FETCH.
- Address advance: mem_addr+1; if mem_addr == 2^LOGSIZE-1, go to DONE instead (no wrap).
- DONE: playing=0, done=1; song_time keeps counting; start -> restart as from IDLE.
- song_time: increments on tick while playing; saturates at 16'hFFFF.
- Notes emitted strictly in memory order; out-of-order times emit immediately once reached.

## Timing
- Reset values: mem_addr=0, note_valid=0, all note fields 0, song_time=0, playing=0, done=0, state IDLE.
- Reset mid-playback: immediate return to reset values; pending note dropped.
- start to first mem_dout sample: 3 cycles (start edge, FETCH, WAIT, sample in DECODE).
- Min note-to-note interval with note_ready tied high: 5 cycles (FETCH, WAIT, DECODE, HOLD, EMIT).
- note_valid rises the cycle after the HOLD compare passes; compare uses song_time registered value.
- tick and accept in the same cycle: both take effect.
- start while playing: ignored.

## Configuration
- NOTE_READER_PAUSE_EN: adds input pause (1 bit). When defined, while pause=1 song_time does not advance on tick and HOLD does not release a note; an already-asserted note_valid is held, accepts still allowed. When undefined, port absent and behaviour as above.

## Test plan
- Memory {0x0_1_2_3 note time 100, 0xE0000000}, LEAD=0: start, 99 ticks -> note_valid low; 100th tick -> note_valid next cycle, pitch/string/fret/time match word; accept -> done=1.
- Note at time 1500, LEAD=2000: start -> note_valid within 5 cycles with song_time=0.
- note_ready low 20 cycles -> note_valid and fields stable throughout; single accept on rising ready.
- Reserved code word 0x40000000 at address 1 -> skipped, note at address 2 emitted; no note_valid for address 1.
- LOGSIZE=2, memory full of notes with no end marker -> 4 notes emitted, then done=1, mem_addr=3.
- Reset asserted while note_valid=1 -> outputs return to reset values asynchronously; start afterwards replays from address 0.
